// File: rtl/multicycle_main_fsm.sv
// Main control FSM for the multicycle CPU.
// Sequences fetch / decode / execute over the shared memory, ALU and register file.
// Memory handshake: in FETCH, MEMRD and MEMWR an access is outstanding.
// MemReady=1 means the access completes in this cycle, and the FSM moves on at the next edge.
// MemReady=0 means the FSM holds its state.
// After MAX_WAIT consecutive wait cycles, the access is aborted with a one-cycle BusErr pulse.
// The abort returns the FSM to FETCH.
module multicycle_main_fsm #(
    parameter int MAX_WAIT = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic       MemReady,
    output logic       IRWrite,
    output logic       NextPC,
    output logic       AdrSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic       ALUOp,
    output logic       RegW,
    output logic       MemW,
    output logic       Branch,
    output logic       Illegal,
    output logic       BusErr,
    output logic [3:0] State
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXECR  = 4'd6,
        EXECI  = 4'd7,
        ALUWB  = 4'd8,
        BRANCH = 4'd9
    } state_t;

    localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

    state_t     state_q, state_d;
    logic [7:0] wait_q, wait_d;
    logic       timeout;
    logic       irwrite_c, nextpc_c, regw_c, memw_c, branch_c, illegal_c, buserr_c;

    // Funct[4:1] belong to the ALU decoder, not to sequencing.
    logic funct_unused;
    assign funct_unused = ^Funct[4:1];

    // State register and wait counter; reset returns to FETCH with no wait pending.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FETCH;
            wait_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    // Next-state decode plus selects and raw (pre-reset-gating) strobes.
    always_comb begin
        state_d   = state_q;
        AdrSrc    = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 2'b00;
        ResultSrc = 2'b00;
        ALUOp     = 1'b0;
        irwrite_c = 1'b0;
        nextpc_c  = 1'b0;
        regw_c    = 1'b0;
        memw_c    = 1'b0;
        branch_c  = 1'b0;
        illegal_c = 1'b0;
        buserr_c  = 1'b0;
        // Completion in the same cycle the limit is reached wins over the abort.
        timeout   = (wait_q == MAX_WAIT_C) && !MemReady;
        case (state_q)
            FETCH: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                if (MemReady) begin
                    irwrite_c = 1'b1;
                    nextpc_c  = 1'b1;
                    state_d   = DECODE;
                end else if (timeout) begin
                    buserr_c  = 1'b1;
                end
            end
            DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                case (Op)
                    2'b00:   state_d = Funct[5] ? EXECI : EXECR;
                    2'b01:   state_d = MEMADR;
                    2'b10:   state_d = BRANCH;
                    default: begin
                        illegal_c = 1'b1;
                        state_d   = FETCH;
                    end
                endcase
            end
            MEMADR: begin
                ALUSrcB = 2'b01;
                state_d = Funct[0] ? MEMRD : MEMWR;
            end
            MEMRD: begin
                AdrSrc = 1'b1;
                if (MemReady) begin
                    state_d = MEMWB;
                end else if (timeout) begin
                    buserr_c = 1'b1;
                    state_d  = FETCH;
                end
            end
            MEMWB: begin
                ResultSrc = 2'b01;
                regw_c    = 1'b1;
                state_d   = FETCH;
            end
            MEMWR: begin
                AdrSrc = 1'b1;
                // Write strobe only in the completing cycle so memory sees exactly one write.
                if (MemReady) begin
                    memw_c  = 1'b1;
                    state_d = FETCH;
                end else if (timeout) begin
                    buserr_c = 1'b1;
                    state_d  = FETCH;
                end
            end
            EXECR: begin
                ALUOp   = 1'b1;
                state_d = ALUWB;
            end
            EXECI: begin
                ALUSrcB = 2'b01;
                ALUOp   = 1'b1;
                state_d = ALUWB;
            end
            ALUWB: begin
                regw_c  = 1'b1;
                state_d = FETCH;
            end
            BRANCH: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                branch_c  = 1'b1;
                state_d   = FETCH;
            end
            default: state_d = FETCH;
        endcase
    end

    // Wait counter counts only uninterrupted waiting in the same memory state.
    always_comb begin
        wait_d = 8'd0;
        if ((state_q == FETCH || state_q == MEMRD || state_q == MEMWR) &&
            !MemReady && !timeout) begin
            wait_d = wait_q + 8'd1;
        end
    end

    // Strobes are forced low while reset is held, even though FETCH is already visible.
    assign IRWrite = irwrite_c & ~reset;
    assign NextPC  = nextpc_c  & ~reset;
    assign RegW    = regw_c    & ~reset;
    assign MemW    = memw_c    & ~reset;
    assign Branch  = branch_c  & ~reset;
    assign Illegal = illegal_c & ~reset;
    assign BusErr  = buserr_c  & ~reset;
    assign State   = state_q;

endmodule
